// File: rtl/systolic_feeder.sv
// systolic_feeder: operand buffer and skewed stream generator for an NxN systolic array.
// Holds matrices A and B, clears the array, streams A rows west / B columns north
// with diagonal skew, flushes until PE(N-1,N-1) has its last product, then pulses done.
module systolic_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [IDX_W-1:0]      wr_row,
    input  logic [IDX_W-1:0]      wr_col,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_err,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  arr_clr,
    output logic [N*DATA_W-1:0]   a_feed,
    output logic [N*DATA_W-1:0]   b_feed,
    output logic                  feed_valid
);

    localparam int unsigned CNT_W    = $clog2(2 * N);
    localparam int unsigned LANES_W  = N * DATA_W;
    localparam int unsigned FEED_END = 2 * N - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_FLUSH
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;

    logic [DATA_W-1:0]   a_mem [N][N];
    logic [DATA_W-1:0]   b_mem [N][N];

    logic                wr_ok_c;
    logic                feed_nxt_c;
    logic [CNT_W-1:0]    t_nxt_c;
    logic [LANES_W-1:0]  a_skew_c;
    logic [LANES_W-1:0]  b_skew_c;

    // A write lands only in IDLE and only if no start is being taken on the same edge
    assign wr_ok_c = wr_en && (state == S_IDLE) && !start;

    // Feed counter value that the next cycle will present, and whether it is a feed cycle
    always_comb begin
        feed_nxt_c = 1'b0;
        t_nxt_c    = '0;
        if (state == S_CLR) begin
            feed_nxt_c = 1'b1;
        end else if ((state == S_FEED) && (cnt != CNT_W'(FEED_END))) begin
            feed_nxt_c = 1'b1;
            t_nxt_c    = cnt + CNT_W'(1);
        end
    end

    // Diagonal skew: lane i carries element (t - i) of its row/column, zero outside the matrix
    always_comb begin
        int d;
        d        = 0;
        a_skew_c = '0;
        b_skew_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            d = int'(t_nxt_c) - int'(i);
            if ((d >= 0) && (d < int'(N))) begin
                a_skew_c[i*DATA_W +: DATA_W] = a_mem[IDX_W'(i)][IDX_W'(d)];
                b_skew_c[i*DATA_W +: DATA_W] = b_mem[IDX_W'(d)][IDX_W'(i)];
            end
        end
    end

    // Operand buffers; frozen for the whole sequence because writes are refused while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (wr_ok_c) begin
            if (wr_sel) begin
                b_mem[wr_row][wr_col] <= wr_data;
            end else begin
                a_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Sequencer with registered outputs: each state's outputs appear in the cycle it is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arr_clr    <= 1'b0;
            wr_err     <= 1'b0;
            feed_valid <= 1'b0;
            a_feed     <= '0;
            b_feed     <= '0;
        end else begin
            arr_clr    <= 1'b0;
            done       <= 1'b0;
            wr_err     <= wr_en && !wr_ok_c;
            feed_valid <= feed_nxt_c;
            a_feed     <= feed_nxt_c ? a_skew_c : '0;
            b_feed     <= feed_nxt_c ? b_skew_c : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                    end
                end
                S_CLR: begin
                    state <= S_FEED;
                    cnt   <= '0;
                end
                S_FEED: begin
                    if (cnt == CNT_W'(FEED_END)) begin
                        state <= S_FLUSH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (cnt == CNT_W'(N)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 4x4 systolic array. Holds two 4x4 8-bit operand matrices A and B, loaded through a simple write port.
- On start, clears the array accumulators, then streams A rows and B columns with diagonal skew into the array's west (A) and north (B) edges.
- Pads with zeros until the last partial product has reached PE(3,3), then pulses done.

Parameters:
- DATA_W, 8, operand width in bits.
- N, 4, array dimension. Schedule lengths scale with N; verification is required only at N=4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- wr_en  input  1  operand write strobe.
- wr_sel  input  1  0 = matrix A, 1 = matrix B.
- wr_row  input  2  row index.
- wr_col  input  2  column index.
- wr_data  input  DATA_W  element value.
- wr_err  output  1  one-cycle pulse when a write is rejected.
- start  input  1  begin a feed sequence.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; array results are valid.
- arr_clr  output  1  one-cycle accumulator-clear pulse to the array.
- a_feed  output  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W] drives array input Ai.
- b_feed  output  N*DATA_W  lane j drives array input Bj.
- feed_valid  output  1  high while FEED is issuing operand data.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Both matrix buffers are zeroed.
  - All outputs are 0.
- All outputs are registered.
- State machine:
  - IDLE -> CLR when start=1.
  - CLR lasts 1 cycle, then -> FEED.
  - FEED lasts 2N-1 cycles, with feed counter t = 0..2N-2, then -> FLUSH.
  - FLUSH lasts N+1 cycles, then -> IDLE.
- Output timing: the state's outputs appear in the cycle the state is entered.
  - Start sampled at edge k: arr_clr=1 and busy=1 during cycle k+1.
  - FEED t=0 appears in cycle k+2.
  - done=1 in the cycle IDLE is re-entered, with busy=0 that same cycle.
  - Total busy = 1 + (2N-1) + (N+1) = 13 cycles at N=4.
- Skew, during FEED at counter t:
  - a_feed lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_feed lane j = B[t-j][j] if 0 <= t-j < N, else 0.
- In all states except FEED, a_feed = b_feed = 0 and feed_valid = 0.
- arr_clr is high only in CLR.
- Writes:
  - Accepted only when the state is IDLE and no start is being accepted on the same edge; the write lands on that edge.
  - wr_en=1 with start=1 in IDLE: start is accepted and the write is rejected (wr_err=1 next cycle). The feed must use a frozen matrix.
  - wr_en=1 while busy: rejected, buffers unchanged, wr_err pulses one cycle later.
- start while busy is ignored: no restart and no error.
- start held high continuously: the next sequence begins on the edge after done (the IDLE cycle samples start again).
- Reset mid-sequence:
  - Immediate abort: outputs go to 0 and buffers are zeroed.
  - No done is issued.
  - The downstream array must also be reset or cleared before reuse.
- No arithmetic in this block; data is passed unmodified at DATA_W bits.

Test Plan:
- Reset, then idle 3 cycles -> busy, done, arr_clr, feed_valid, a_feed, b_feed all 0.
- Load A[i][k]=4i+k+1 and B = identity, pulse start -> arr_clr in cycle 1; at FEED t=0 a_feed lanes = {1,0,0,0} (lane 0 first) and b_feed = {1,0,0,0}; at t=3 a_feed = {4,7,10,13}; at t=6 a_feed = {0,0,0,16}; done 13 cycles after start. Feed the connected array -> r[i][j] = A[i][j].
- Load A = B = all 2s, run, connected array -> every result 16 at done; a second start right after done gives 16 again (arr_clr clears, no accumulation to 32).
- Write with wr_en during FEED (A[0][0]=99) -> wr_err pulses, stream unchanged; the rerun still shows the original A[0][0].
- start and wr_en asserted on the same IDLE edge -> sequence starts, wr_err=1 next cycle, buffer unchanged.
- rst=0 asserted mid-FEED (t=3) -> outputs 0 immediately without a clock edge; after release no done pulse, and a readback run streams only zeros.
